booth_window_sequencer: RTL and testbench

Radix-4 Booth recoding sequencer for the multdiv multiplier datapath. It sits directly upstream of the 3-to-8 select decoder. It latches the multiplier operand and emits one 3-bit Booth window per accepted step, LSB window first. The decoder turns each window into a one-hot partial-product select for the accumulate stage: 0/7 zero, 1/2 +M, 3 +2M, 4 -2M, 5/6 -M.

---
 rtl/booth_window_sequencer.sv | 126 ++++++++++++
 tb/tb_booth_window_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/booth_window_sequencer.sv
// Radix-4 Booth window sequencer: latches the multiplier and emits one 3-bit window per accepted step.
// Optional early termination on a trivial remainder is enabled with `define BOOTH_EARLY_EXIT_EN.
module booth_window_sequencer #(
  parameter  int WIDTH = 32,
  localparam int STEPS = WIDTH / 2,
  localparam int CNT_W = $clog2(STEPS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplier,
  output logic [2:0]       select,
  output logic             win_valid,
  input  logic             win_ready,
  output logic             win_last,
  output logic [CNT_W-1:0] step,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             qm1_q, qm1_d;
  logic [CNT_W-1:0] step_q, step_d;

  logic [WIDTH-1:0] shreg_shift;
  logic             last_step;
  logic             remainder_trivial;
  logic             next_trivial;
  logic             accept;

  assign shreg_shift = {{2{shreg_q[WIDTH-1]}}, shreg_q[WIDTH-1:2]};
  assign last_step   = (step_q == CNT_W'(STEPS - 1));
  assign accept      = win_valid && win_ready;

`ifdef BOOTH_EARLY_EXIT_EN
  // Trivial: every remaining window would be 000 or 111, i.e. a zero partial product.
  assign remainder_trivial = (shreg_q == {WIDTH{shreg_q[WIDTH-1]}}) &&
                             (qm1_q == shreg_q[WIDTH-1]);
  assign next_trivial      = (shreg_shift == {WIDTH{shreg_q[WIDTH-1]}}) &&
                             (shreg_q[1] == shreg_q[WIDTH-1]);
`else
  assign remainder_trivial = 1'b0;
  assign next_trivial      = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      qm1_q   <= 1'b0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      qm1_q   <= qm1_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    qm1_d   = qm1_q;
    step_d  = step_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          shreg_d = multiplier;
          qm1_d   = 1'b0;
          step_d  = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (remainder_trivial) begin
          state_d = S_DONE;
        end else if (accept) begin
          shreg_d = shreg_shift;
          qm1_d   = shreg_q[1];
          // Counter holds on the final window so it never wraps inside an operation.
          step_d  = last_step ? step_q : step_q + CNT_W'(1);
          if (win_last) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    win_valid = 1'b0;
    select    = 3'b000;
    win_last  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    step      = step_q;
    unique case (state_q)
      S_RUN: begin
        busy      = 1'b1;
        win_valid = !remainder_trivial;
        if (!remainder_trivial) begin
          select   = {shreg_q[1], shreg_q[0], qm1_q};
          win_last = last_step || next_trivial;
        end
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_booth_window_sequencer.sv
// Self-checking bench for booth_window_sequencer against a bit-window reference model.
module tb_booth_window_sequencer;
  localparam int WIDTH = 32;
  localparam int STEPS = WIDTH / 2;
  localparam int CNT_W = $clog2(STEPS);

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] multiplier;
  logic [2:0]       select;
  logic             win_valid;
  logic             win_ready;
  logic             win_last;
  logic [CNT_W-1:0] step;
  logic             busy;
  logic             done;

  int n_pass  = 0;
  int n_total = 0;

  logic [2:0] exp_sel [STEPS];
  int         exp_n;

  always #5 clock = ~clock;

  booth_window_sequencer #(.WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .multiplier (multiplier),
    .select     (select),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_last   (win_last),
    .step       (step),
    .busy       (busy),
    .done       (done)
  );

  // Window i is bits [2i+1 : 2i-1] of the multiplier with an implied zero below bit 0.
  task automatic build_model(input logic [WIDTH-1:0] m);
    logic [WIDTH:0] ext;
    ext = {m, 1'b0};
    for (int i = 0; i < STEPS; i++) exp_sel[i] = 3'((ext >> (2 * i)) & 7);
    exp_n = STEPS;
`ifdef BOOTH_EARLY_EXIT_EN
    for (int n = STEPS; n >= 0; n--) begin
      logic signed [WIDTH:0] rem;
      rem = $signed(ext) >>> (2 * n);
      if (rem == 0 || rem == -1) exp_n = n;
    end
`endif
  endtask

  // mode 0: ready high; mode 1: ready pattern 1,0,0 with a stray start; mode 2: random ready and starts
  task automatic run_op(input logic [WIDTH-1:0] m, input int mode, input string tag);
    int  idx;
    int  cyc;
    bit  seen_done;
    build_model(m);
    start = 1'b1;
    multiplier = m;
    win_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    multiplier = $urandom;
    idx = 0;
    seen_done = 0;
    for (cyc = 0; cyc < 400 && !seen_done; cyc++) begin
      n_total++;
      if (busy !== 1'b1) $display("FAIL %s busy cyc %0d got %b want 1", tag, cyc, busy);
      else n_pass++;
      if (cyc == 0) begin
        n_total++;
        if (win_valid !== (exp_n > 0)) $display("FAIL %s first_valid got %b want %b", tag, win_valid, exp_n > 0);
        else n_pass++;
      end
      if (done === 1'b1) begin
        seen_done = 1;
        n_total++;
        if (idx != exp_n) $display("FAIL %s window_count got %0d want %0d", tag, idx, exp_n);
        else n_pass++;
        n_total++;
        if (win_valid !== 1'b0) $display("FAIL %s valid_in_done got %b want 0", tag, win_valid);
        else n_pass++;
        if (mode == 0) begin
          n_total++;
          if (cyc != ((exp_n == 0) ? 1 : exp_n)) $display("FAIL %s done_latency got %0d want %0d", tag, cyc, (exp_n == 0) ? 1 : exp_n);
          else n_pass++;
        end
      end else if (win_valid === 1'b1) begin
        n_total++;
        if (idx >= exp_n) begin
          $display("FAIL %s extra_window idx %0d got valid want none", tag, idx);
        end else if (select !== exp_sel[idx] || step !== CNT_W'(idx) || win_last !== (idx == exp_n - 1)) begin
          $display("FAIL %s window %0d got sel=%0d step=%0d last=%b want sel=%0d step=%0d last=%b",
                   tag, idx, select, step, win_last, exp_sel[idx], idx, idx == exp_n - 1);
        end else n_pass++;
      end
      case (mode)
        0: win_ready = 1'b1;
        1: win_ready = (cyc % 3 == 0);
        default: win_ready = 1'($urandom_range(0, 1));
      endcase
      if (win_valid === 1'b1 && win_ready) idx++;
      if ((mode == 1 && cyc == 3) || (mode == 2 && $urandom_range(0, 7) == 0)) begin
        start = 1'b1;
        multiplier = $urandom;
      end
      @(posedge clock); #1;
      start = 1'b0;
    end
    if (!seen_done) begin
      n_total++;
      $display("FAIL %s timeout got no done want done within 400 cycles", tag);
    end
    n_total++;
    if (done !== 1'b0 || busy !== 1'b0 || win_valid !== 1'b0 || select !== 3'b000)
      $display("FAIL %s after_done got done=%b busy=%b valid=%b sel=%0d want 0 0 0 0", tag, done, busy, win_valid, select);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    multiplier = $urandom;
    win_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_total++;
    if (select !== 3'b000 || win_valid !== 1'b0 || win_last !== 1'b0 || step !== '0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_state got sel=%0d v=%b l=%b step=%0d busy=%b done=%b want all 0",
               select, win_valid, win_last, step, busy, done);
    else n_pass++;
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL idle_hold got busy=%b done=%b want 0 0", busy, done);
    else n_pass++;
  endtask

  task automatic test_directed();
    run_op(32'h0000_0003, 0, "m3");
    run_op(32'hFFFF_FFFF, 0, "mneg1");
    run_op(32'h8000_0000, 0, "mmin");
    run_op(32'h0000_0000, 0, "mzero");
  endtask

  task automatic test_backpressure();
    run_op(32'h0000_0005, 1, "m5_bp");
  endtask

  task automatic test_reset_mid_op();
    int  cyc;
    bit  hit;
    build_model(32'h1234_5678);
    start = 1'b1;
    multiplier = 32'h1234_5678;
    win_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    hit = 0;
    for (cyc = 0; cyc < 40 && !hit; cyc++) begin
      if (win_valid === 1'b1 && step === CNT_W'(7)) hit = 1;
      else begin
        @(posedge clock); #1;
      end
    end
    n_total++;
    if (!hit) $display("FAIL midreset_reach got no step7 want step7 window");
    else n_pass++;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    n_total++;
    if (win_valid !== 1'b0 || busy !== 1'b0 || step !== '0 || done !== 1'b0 || select !== 3'b000)
      $display("FAIL midreset_state got v=%b busy=%b step=%0d done=%b sel=%0d want 0 0 0 0 0",
               win_valid, busy, step, done, select);
    else n_pass++;
    hit = 0;
    repeat (5) begin
      if (done !== 1'b0 || busy !== 1'b0) hit = 1;
      @(posedge clock); #1;
    end
    n_total++;
    if (hit) $display("FAIL midreset_quiet got activity want none");
    else n_pass++;
    run_op($urandom, 0, "after_reset");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) run_op($urandom, 0, "b2b");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      logic [WIDTH-1:0] m;
      m = $urandom;
      if (i % 7 == 3) m = '0;
      if (i % 7 == 5) m = '1;
      if (i % 7 == 6) m = m >> $urandom_range(0, WIDTH - 1);
      run_op(m, 2, "rand");
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    multiplier = '0;
    win_ready = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
